// File: rtl/ddr_ring_burst_scheduler.sv
// Ring-of-bursts scheduler for the ADC capture -> DDR -> Ethernet path.
// Round-robins write/read requests and issues one burst command at a time to the AXI burst engine.
module ddr_ring_burst_scheduler #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 11,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
    parameter int                    BURST_BYTES = 4096,
    parameter int                    RING_BURSTS = 1000
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_rw,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_done,
    input  logic                  cmd_err,
    output logic                  wr_grant,
    output logic                  rd_grant,
    output logic [CNT_WIDTH-1:0]  fill,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    localparam int                   SHIFT     = $clog2(BURST_BYTES);
    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(RING_BURSTS - 1);
    localparam logic [CNT_WIDTH-1:0] RING_MAX  = CNT_WIDTH'(RING_BURSTS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_WIDTH-1:0]    r_wr_ptr;
    logic [CNT_WIDTH-1:0]    r_rd_ptr;
    logic [CNT_WIDTH-1:0]    r_fill;
    logic                    r_last_rd;
    logic                    r_clear_pend;
    logic                    r_cmd_valid;
    logic                    r_cmd_rw;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic                    r_wr_grant;
    logic                    r_rd_grant;
    logic [7:0]              r_err_cnt;

    logic                    w_idle;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_elig;
    logic                    w_rd_elig;
    logic                    w_do_clear;
    logic                    w_sel_wr;
    logic                    w_sel_rd;
    logic                    w_accept;
    logic                    w_done_ok;
    logic                    w_done_err;
    logic                    w_busy;
    logic [CNT_WIDTH-1:0]    w_sel_ptr;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;

    assign w_idle     = (r_state == S_IDLE);
    assign w_full     = (r_fill == RING_MAX);
    assign w_empty    = (r_fill == '0);
    assign w_wr_elig  = enable & wr_req & ~w_full  & ~r_clear_pend;
    assign w_rd_elig  = enable & rd_req & ~w_empty & ~r_clear_pend;
    assign w_do_clear = w_idle & (r_clear_pend | clear);
    // Contention goes to the side that did not win last time.
    assign w_sel_wr   = w_idle & ~clear & w_wr_elig & (~w_rd_elig | r_last_rd);
    assign w_sel_rd   = w_idle & ~clear & w_rd_elig & (~w_wr_elig | ~r_last_rd);
    assign w_accept   = (r_state == S_ISSUE) & r_cmd_valid & cmd_ready;
    assign w_done_ok  = (r_state == S_WAIT) & cmd_done & ~cmd_err;
    assign w_done_err = (r_state == S_WAIT) & cmd_done & cmd_err;
    assign w_sel_ptr  = w_sel_rd ? r_rd_ptr : r_wr_ptr;
    assign w_sel_addr = BASE_ADDR + (ADDR_WIDTH'(w_sel_ptr) << SHIFT);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_wr | w_sel_rd) w_next = S_ISSUE;
            S_ISSUE: if (w_accept)            w_next = S_WAIT;
            S_WAIT:  if (cmd_done)            w_next = S_IDLE;
            default:                          w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_last_rd    <= 1'b1;
            r_clear_pend <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_rw     <= 1'b0;
            r_cmd_addr   <= '0;
            r_wr_grant   <= 1'b0;
            r_rd_grant   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_wr_grant <= 1'b0;
            r_rd_grant <= 1'b0;
            if (w_sel_wr | w_sel_rd) begin
                r_cmd_valid <= 1'b1;
                r_cmd_rw    <= w_sel_rd;
                r_cmd_addr  <= w_sel_addr;
            end
            if (w_accept) begin
                r_cmd_valid <= 1'b0;
                r_wr_grant  <= ~r_cmd_rw;
                r_rd_grant  <= r_cmd_rw;
                r_last_rd   <= r_cmd_rw;
            end
            // A clear seen mid-command is deferred until the command retires.
            if (clear & ~w_idle)
                r_clear_pend <= 1'b1;
            if (w_do_clear) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_fill       <= '0;
                r_clear_pend <= 1'b0;
            end else if (w_done_ok) begin
                if (r_cmd_rw) begin
                    r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + CNT_WIDTH'(1);
                    r_fill   <= r_fill - CNT_WIDTH'(1);
                end else begin
                    r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + CNT_WIDTH'(1);
                    r_fill   <= r_fill + CNT_WIDTH'(1);
                end
            end
            if (w_done_err && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_rw    = r_cmd_rw;
    assign cmd_addr  = r_cmd_addr;
    assign wr_grant  = r_wr_grant;
    assign rd_grant  = r_rd_grant;
    assign fill      = r_fill;
    assign full      = w_full;
    assign empty     = w_empty;
    assign busy      = w_busy;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ddr_ring_burst_scheduler.sv
// Directed bench for ddr_ring_burst_scheduler: a small burst-engine responder plus
// per-scenario tasks with hand-computed expected addresses, fill levels and grants.
module tb_ddr_ring_burst_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        wr_req;
    logic        rd_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [31:0] cmd_addr;
    logic        cmd_done;
    logic        cmd_err;
    logic        wr_grant;
    logic        rd_grant;
    logic [10:0] fill;
    logic        full;
    logic        empty;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_pass;
    int n_total;

    ddr_ring_burst_scheduler dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .enable        (enable),
        .clear         (clear),
        .wr_req        (wr_req),
        .rd_req        (rd_req),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_addr      (cmd_addr),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .wr_grant      (wr_grant),
        .rd_grant      (rd_grant),
        .fill          (fill),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .err_cnt       (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine responder: waits for a command (bounded), accepts it, then completes it after 'delay' cycles.
    task automatic engine(input int delay, input bit err, input bit pulse_clr,
                          output bit got, output logic rw, output logic [31:0] addr,
                          output int lat, output logic gw, output logic gr);
        got  = 1'b0;
        lat  = 0;
        rw   = 1'bx;
        addr = 'x;
        gw   = 1'bx;
        gr   = 1'bx;
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!got) return;
        rw        = cmd_rw;
        addr      = cmd_addr;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        gw        = wr_grant;
        gr        = rd_grant;
        if (pulse_clr) clear = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            clear = 1'b0;
        end
        cmd_done = 1'b1;
        cmd_err  = err;
        @(negedge clk);
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
    endtask

    task automatic test_reset();
        n_total++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (fill !== 11'd0) $display("FAIL reset_fill got %0d want 0", fill); else n_pass++;
        n_total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); else n_pass++;
        n_total++; if (cmd_addr !== 32'h0 || cmd_rw !== 1'b0) $display("FAIL reset_cmd got addr=%h rw=%b want 0 0", cmd_addr, cmd_rw); else n_pass++;
        n_total++; if (err_cnt !== 8'd0 || wr_grant !== 1'b0 || rd_grant !== 1'b0) $display("FAIL reset_misc got err=%0d wg=%b rg=%b want 0", err_cnt, wr_grant, rd_grant); else n_pass++;
    endtask

    task automatic test_write3();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h4000_0000;
        exp_addr[1] = 32'h4000_1000;
        exp_addr[2] = 32'h4000_2000;
        wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            engine(5, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
            if (k == 2) wr_req = 1'b0;
            n_total++; if (!got || addr !== exp_addr[k] || rw !== 1'b0) $display("FAIL write3_cmd[%0d] got valid=%b addr=%h rw=%b want addr=%h rw=0", k, got, addr, rw, exp_addr[k]); else n_pass++;
            n_total++; if (gw !== 1'b1 || gr !== 1'b0) $display("FAIL write3_grant[%0d] got wg=%b rg=%b want 1 0", k, gw, gr); else n_pass++;
            if (k > 0) begin
                n_total++; if (lat !== 1) $display("FAIL write3_latency[%0d] got %0d want 1", k, lat); else n_pass++;
            end
        end
        n_total++; if (fill !== 11'd3) $display("FAIL write3_fill got %0d want 3", fill); else n_pass++;
    endtask

    task automatic test_alternate();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        logic        exp_rw   [4];
        logic [31:0] exp_addr [4];
        logic [10:0] exp_fill [4];
        exp_rw[0] = 1'b0; exp_addr[0] = 32'h4000_3000; exp_fill[0] = 11'd3;
        exp_rw[1] = 1'b1; exp_addr[1] = 32'h4000_1000; exp_fill[1] = 11'd2;
        exp_rw[2] = 1'b0; exp_addr[2] = 32'h4000_4000; exp_fill[2] = 11'd3;
        exp_rw[3] = 1'b1; exp_addr[3] = 32'h4000_2000; exp_fill[3] = 11'd2;
        rd_req = 1'b1;
        engine(3, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        wr_req = 1'b1;
        n_total++; if (!got || addr !== 32'h4000_0000 || rw !== 1'b1 || fill !== 11'd2) $display("FAIL alt_first_read got addr=%h rw=%b fill=%0d want 40000000 1 2", addr, rw, fill); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            engine(3, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
            if (k == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
            n_total++; if (!got || rw !== exp_rw[k] || addr !== exp_addr[k]) $display("FAIL alt_cmd[%0d] got rw=%b addr=%h want rw=%b addr=%h", k, rw, addr, exp_rw[k], exp_addr[k]); else n_pass++;
            n_total++; if (gw !== ~exp_rw[k] || gr !== exp_rw[k]) $display("FAIL alt_grant[%0d] got wg=%b rg=%b", k, gw, gr); else n_pass++;
            n_total++; if (fill !== exp_fill[k]) $display("FAIL alt_fill[%0d] got %0d want %0d", k, fill, exp_fill[k]); else n_pass++;
        end
    endtask

    task automatic test_error_retry();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        rd_req = 1'b1;
        engine(2, 1'b1, 1'b0, got, rw, addr, lat, gw, gr);
        n_total++; if (!got || addr !== 32'h4000_3000 || rw !== 1'b1) $display("FAIL err_cmd got addr=%h rw=%b want 40003000 1", addr, rw); else n_pass++;
        n_total++; if (fill !== 11'd2 || err_cnt !== 8'd1) $display("FAIL err_state got fill=%0d err=%0d want 2 1", fill, err_cnt); else n_pass++;
        engine(2, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        rd_req = 1'b0;
        n_total++; if (!got || addr !== 32'h4000_3000 || rw !== 1'b1) $display("FAIL err_retry got addr=%h rw=%b want 40003000 1", addr, rw); else n_pass++;
        n_total++; if (fill !== 11'd1 || err_cnt !== 8'd1) $display("FAIL err_after_retry got fill=%0d err=%0d want 1 1", fill, err_cnt); else n_pass++;
    endtask

    task automatic test_clear();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        wr_req = 1'b1;
        for (int k = 0; k < 4; k++) engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        n_total++; if (fill !== 11'd5) $display("FAIL clear_prefill got %0d want 5", fill); else n_pass++;
        engine(4, 1'b0, 1'b1, got, rw, addr, lat, gw, gr);
        n_total++; if (!got || addr !== 32'h4000_9000 || fill !== 11'd6) $display("FAIL clear_inflight got addr=%h fill=%0d want 40009000 6", addr, fill); else n_pass++;
        @(negedge clk);
        n_total++; if (fill !== 11'd0 || empty !== 1'b1) $display("FAIL clear_applied got fill=%0d empty=%b want 0 1", fill, empty); else n_pass++;
        n_total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL clear_no_grant got valid=%b busy=%b want 0 0", cmd_valid, busy); else n_pass++;
        engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        n_total++; if (!got || addr !== 32'h4000_0000 || lat !== 1) $display("FAIL clear_wrptr got addr=%h lat=%0d want 40000000 1", addr, lat); else n_pass++;
    endtask

    task automatic test_full_wrap();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        logic [31:0] exp_addr;
        bit saw_valid;
        for (int k = 1; k < 1000; k++) begin
            exp_addr = 32'h4000_0000 + 32'(k) * 32'h1000;
            engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
            n_total++;
            if (!got || addr !== exp_addr) begin
                $display("FAIL full_fill_addr[%0d] got valid=%b addr=%h want %h", k, got, addr, exp_addr);
                break;
            end else n_pass++;
        end
        n_total++; if (fill !== 11'd1000 || full !== 1'b1) $display("FAIL full_flag got fill=%0d full=%b want 1000 1", fill, full); else n_pass++;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid === 1'b1 || busy === 1'b1) saw_valid = 1'b1;
        end
        n_total++; if (saw_valid !== 1'b0) $display("FAIL full_blocks_write got activity=%b want 0", saw_valid); else n_pass++;
        wr_req = 1'b0;
        rd_req = 1'b1;
        engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        rd_req = 1'b0;
        n_total++; if (!got || rw !== 1'b1 || addr !== 32'h4000_0000 || fill !== 11'd999) $display("FAIL full_read got rw=%b addr=%h fill=%0d want 1 40000000 999", rw, addr, fill); else n_pass++;
        wr_req = 1'b1;
        engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        wr_req = 1'b0;
        n_total++; if (!got || rw !== 1'b0 || addr !== 32'h4000_0000 || fill !== 11'd1000) $display("FAIL wrap_write got rw=%b addr=%h fill=%0d want 0 40000000 1000", rw, addr, fill); else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        bit got; logic rw; logic [31:0] addr; int lat; logic gw, gr;
        bit seen;
        seen   = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin seen = 1'b1; break; end
        end
        n_total++; if (seen !== 1'b1) $display("FAIL rst_mid_issue got no cmd_valid want 1"); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_async got valid=%b busy=%b want 0 0", cmd_valid, busy); else n_pass++;
        n_total++; if (fill !== 11'd0 || empty !== 1'b1 || err_cnt !== 8'd0) $display("FAIL rst_mid_state got fill=%0d empty=%b err=%0d want 0 1 0", fill, empty, err_cnt); else n_pass++;
        @(negedge clk);
        rst_n  = 1'b1;
        wr_req = 1'b1;
        engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        n_total++; if (!got || rw !== 1'b0 || addr !== 32'h4000_0000) $display("FAIL rst_first_write got rw=%b addr=%h want 0 40000000", rw, addr); else n_pass++;
        engine(1, 1'b0, 1'b0, got, rw, addr, lat, gw, gr);
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_total++; if (!got || rw !== 1'b1 || addr !== 32'h4000_0000 || fill !== 11'd0) $display("FAIL rst_then_read got rw=%b addr=%h fill=%0d want 1 40000000 0", rw, addr, fill); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_err   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_write3();
        test_alternate();
        test_error_retry();
        test_clear();
        test_full_wrap();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ddr_ring_burst_scheduler.md
Name: ddr_ring_burst_scheduler

Overview:
- Sequences the AXI4 full-burst engine that moves ADC capture data into DDR and reads it back out for the Ethernet path.
- Treats a DDR region as a ring of fixed-size bursts and tracks write pointer, read pointer and fill level.
- Arbitrates round-robin between the capture side (write request) and the ETH side (read request).
- Issues one burst command at a time (direction + address) to the burst engine and waits for its completion before issuing the next.

Parameters:
- BASE_ADDR, 32'h40000000, DDR byte address of ring slot 0.
- BURST_BYTES, 4096, bytes per burst (256 beats x 16 B); must be a power of two.
- RING_BURSTS, 1000, number of burst slots in the ring.
- ADDR_WIDTH, 32, width of cmd_addr.
- CNT_WIDTH, 11, width of pointers and fill counter; must satisfy 2^CNT_WIDTH > RING_BURSTS.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- enable  in  1  when low, no new grants; an in-flight command completes normally.
- clear  in  1  single-cycle pulse; empties the ring.
- wr_req  in  1  level; capture FIFO holds at least one burst of data.
- rd_req  in  1  level; ETH side has space for at least one burst.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  engine accepts the command.
- cmd_rw  out  1  0 = write burst, 1 = read burst.
- cmd_addr  out  ADDR_WIDTH  burst start address.
- cmd_done  in  1  one-cycle pulse when the engine finishes the burst (B response, or RLAST accepted).
- cmd_err  in  1  qualified by cmd_done; non-OKAY response.
- wr_grant  out  1  one-cycle pulse when a write command is accepted.
- rd_grant  out  1  one-cycle pulse when a read command is accepted.
- fill  out  CNT_WIDTH  bursts stored and not yet read.
- full  out  1  fill == RING_BURSTS.
- empty  out  1  fill == 0.
- busy  out  1  FSM not in IDLE.
- err_cnt  out  8  count of cmd_done with cmd_err; saturates at 255.

Behaviour:
- Reset values (async on ARESETN low):
  - FSM = IDLE.
  - cmd_valid, cmd_rw, cmd_addr, wr_grant, rd_grant, busy, err_cnt = 0.
  - wr_ptr, rd_ptr, fill = 0; empty = 1; full = 0.
  - last_grant = read, so the first contention goes to write.
  - clear_pend = 0.
- Eligibility:
  - wr_elig = enable & wr_req & ~full & ~clear_pend.
  - rd_elig = enable & rd_req & ~empty & ~clear_pend.
- IDLE:
  - If clear_pend or clear: zero wr_ptr, rd_ptr and fill in the next cycle; clear_pend <= 0; no grant this cycle.
  - Otherwise, if exactly one side is eligible, select it.
  - If both are eligible, select the side opposite last_grant.
  - On selection go to ISSUE. In the same edge register cmd_rw, and set cmd_addr = BASE_ADDR + ptr*BURST_BYTES, where ptr = wr_ptr for write, rd_ptr for read.
  - Multiply is a shift (BURST_BYTES is a power of two); result truncated to ADDR_WIDTH.
  - cmd_valid is high in the cycle after the sampled request (1-cycle latency).
- ISSUE:
  - cmd_valid held high; cmd_rw and cmd_addr held stable until cmd_ready.
  - On cmd_valid & cmd_ready:
    - cmd_valid <= 0.
    - Pulse wr_grant or rd_grant in the next cycle.
    - last_grant <= issued direction.
    - Go to WAIT.
  - Request inputs are not resampled while in ISSUE.
- WAIT:
  - On cmd_done without cmd_err, go to IDLE. In the same edge:
    - write: wr_ptr <= (wr_ptr == RING_BURSTS-1) ? 0 : wr_ptr+1, and fill += 1.
    - read: rd_ptr wraps the same way, and fill -= 1.
  - On cmd_done with cmd_err: pointers and fill unchanged (the slot is retried on a later grant); err_cnt += 1 (saturating); go to IDLE.
  - cmd_done outside WAIT is ignored. The engine never asserts cmd_done in the cmd_ready cycle.
- Throughput: earliest next cmd_valid is 2 cycles after cmd_done (IDLE, then ISSUE).
- full and empty are combinational from fill. fill never exceeds RING_BURSTS and never underflows, guaranteed by eligibility.
- clear arriving while busy sets clear_pend. The in-flight command finishes and updates pointers, then the clear is applied on the IDLE cycle.
- enable deasserted mid-command: the command completes and pointers update; no further grants.
- Asserting ARESETN low mid-burst returns everything to reset values immediately. The engine is reset by the same signal.

Test Plan:
- Only wr_req=1 for 3 bursts, cmd_ready=1, cmd_done 5 cycles after accept → cmd_addr = 0x40000000, 0x40001000, 0x40002000, all cmd_rw=0; fill=3; each cmd_valid 2 cycles after the prior cmd_done.
- wr_req=rd_req=1 continuously with fill=2 → grants alternate W,R,W,R starting with W; fill oscillates 3,2,3,2.
- Fill the ring to 1000 with wr_req only → full=1, no further cmd_valid; wr_ptr wrapped to 0; next write after one read uses address 0x40000000.
- Read completes with cmd_err=1 → rd_ptr and fill unchanged, err_cnt=1; next read reissues the same cmd_addr.
- clear pulse during WAIT of a write at fill=5 → write completes (fill=6), then fill=0, empty=1, pointers=0; no grant in the clear cycle.
- Assert ARESETN low while in ISSUE → cmd_valid drops immediately; fill=0; after release, first contention grants write.
